phase_packetizer: RTL and testbench

//  Downstream of the PR3 peak-detect output; captures one run's peak list (sop..eop entries of

---
 rtl/phase_packetizer.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_phase_packetizer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_packetizer.sv
// -----------------------------------------------------------------------------
// phase_packetizer
//
// Captures one run of peak-detect entries (sop..eop, each carrying freq,
// phaseA and phaseB) into one of two capture banks. Each entry is stored
// together with the wrapped phase difference A-B. Every completed run is then
// serialised as a byte frame over a valid/ready stream.
//
// Frame layout, MSB first:
//   SYNC, seq, count, { freq[23:0], phaseA, phaseB, diff } x count [, checksum]
//
// Optional feature macro: PHASE_PACKETIZER_CHECKSUM_EN
//   defined   -> a trailing byte carries the mod-256 sum of every earlier
//                frame byte (SYNC included); source_eop marks that byte.
//   undefined -> no checksum byte; source_eop marks the last diff LSB byte.
//
// Parameters
//   NPEAKS  entries kept per frame (later entries of a run are dropped)
//   SYNC    first byte of every frame
//   PI      pi in Q3.13, used to wrap the phase difference into [-PI, PI]
//
// Ports
//   clk            clock
//   reset          asynchronous reset, active low
//   sink_valid     entry valid
//   sink_sop       first entry of a run
//   sink_eop       last entry of a run
//   sink_freq      frequency, UQ24.0
//   sink_phaseA    phase A, Q3.13
//   sink_phaseB    phase B, Q3.13
//   source_valid   frame byte valid
//   source_ready   consumer accepts the byte
//   source_data    frame byte
//   source_sop     marks the SYNC byte
//   source_eop     marks the last byte of the frame
//   drop_cnt       runs dropped for lack of a free bank (saturates at 255)
// -----------------------------------------------------------------------------
module phase_packetizer #(
    parameter int         NPEAKS = 4,
    parameter logic [7:0] SYNC   = 8'hA5,
    parameter int         PI     = 25736
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    input  logic [23:0] sink_freq,
    input  logic [15:0] sink_phaseA,
    input  logic [15:0] sink_phaseB,
    output logic        source_valid,
    input  logic        source_ready,
    output logic [7:0]  source_data,
    output logic        source_sop,
    output logic        source_eop,
    output logic [7:0]  drop_cnt
);

    // entry counter width (0..NPEAKS), entry address width, frame byte index
    localparam int CW = $clog2(NPEAKS + 1);
    localparam int EW = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
    localparam int IW = $clog2(9 * NPEAKS + 5);

    localparam logic [CW-1:0]      NPEAKS_C = CW'(NPEAKS);
    localparam logic signed [16:0] PI_POS   = 17'(PI);
    localparam logic signed [16:0] PI_NEG   = 17'(-PI);
    localparam logic signed [16:0] TWO_PI   = 17'(2 * PI);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // -------------------------------------------------------------------------
    // Wrapped phase difference, computed on the incoming entry
    // -------------------------------------------------------------------------
    logic signed [16:0] diff_raw;
    logic [15:0]        diff_val;
    logic [71:0]        entry_word;

    always_comb begin
        diff_raw = $signed({sink_phaseA[15], sink_phaseA})
                 - $signed({sink_phaseB[15], sink_phaseB});
        if (diff_raw > PI_POS) begin
            diff_val = 16'(diff_raw - TWO_PI);
        end else if (diff_raw < PI_NEG) begin
            diff_val = 16'(diff_raw + TWO_PI);
        end else begin
            diff_val = 16'(diff_raw);
        end
    end

    assign entry_word = {sink_freq, sink_phaseA, sink_phaseB, diff_val};

    // -------------------------------------------------------------------------
    // Capture side state
    // -------------------------------------------------------------------------
    logic           cap_open_q, cap_open_d;
    logic           cap_bank_q, cap_bank_d;   // bank the next/current run goes into
    logic [CW-1:0]  cap_idx_q,  cap_idx_d;    // entries stored so far, saturating
    logic [7:0]     drop_q,     drop_d;
    logic           bank_full_q [2];
    logic [CW-1:0]  bank_cnt_q  [2];
    logic [71:0]    mem_q [2][NPEAKS];

    logic           wr_en;
    logic [EW-1:0]  wr_addr;
    logic           cap_close;
    logic           bank_avail;

    // Transmit side state
    tx_state_t      state_q, state_d;
    logic           tx_bank_q, tx_bank_d;
    logic [7:0]     seq_q,     seq_d;
    logic [IW-1:0]  idx_q,     idx_d;         // byte index within the frame
    logic [EW-1:0]  ent_q,     ent_d;         // entry being sent
    logic [3:0]     off_q,     off_d;         // byte offset inside that entry
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
    logic [7:0]     cks_q,     cks_d;
`endif
    logic           tx_release;               // last byte accepted this cycle
    logic [CW-1:0]  tx_cnt;
    logic [IW-1:0]  last_idx;
    logic [71:0]    entry_sel;
    logic [7:0]     entry_bytes [9];
    logic [7:0]     frame_byte;

    // -------------------------------------------------------------------------
    // Capture next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cap_open_d = cap_open_q;
        cap_bank_d = cap_bank_q;
        cap_idx_d  = cap_idx_q;
        drop_d     = drop_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        cap_close  = 1'b0;

        // Banks fill and drain in the same alternating order, so only the
        // next capture bank has to be examined. A bank released by the
        // transmitter in this very cycle counts as free.
        bank_avail = !bank_full_q[cap_bank_q]
                   || (tx_release && (tx_bank_q == cap_bank_q));

        if (sink_valid) begin
            if (sink_sop) begin
                // An open frame is never full, so a restart always succeeds.
                if (cap_open_q || bank_avail) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    cap_open_d = 1'b1;
                    cap_idx_d  = CW'(1);
                    cap_close  = sink_eop;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end else if (cap_open_q) begin
                if (cap_idx_q < NPEAKS_C) begin
                    wr_en     = 1'b1;
                    wr_addr   = EW'(cap_idx_q);
                    cap_idx_d = cap_idx_q + CW'(1);
                end
                cap_close = sink_eop;
            end
        end

        if (cap_close) begin
            cap_open_d = 1'b0;
            cap_bank_d = ~cap_bank_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_open_q <= 1'b0;
            cap_bank_q <= 1'b0;
            cap_idx_q  <= '0;
            drop_q     <= 8'd0;
            for (int b = 0; b < 2; b++) begin
                bank_full_q[b] <= 1'b0;
                bank_cnt_q[b]  <= '0;
            end
        end else begin
            cap_open_q <= cap_open_d;
            cap_bank_q <= cap_bank_d;
            cap_idx_q  <= cap_idx_d;
            drop_q     <= drop_d;
            for (int b = 0; b < 2; b++) begin
                if (tx_release && (tx_bank_q == 1'(b))) begin
                    bank_full_q[b] <= 1'b0;
                end
                // Closing wins: a one-entry run may refill a bank freed this cycle.
                if (cap_close && (cap_bank_q == 1'(b))) begin
                    bank_full_q[b] <= 1'b1;
                    bank_cnt_q[b]  <= cap_idx_d;
                end
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by bank_full_q/cnt.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[cap_bank_q][wr_addr] <= entry_word;
        end
    end

    // -------------------------------------------------------------------------
    // Frame byte selection
    // -------------------------------------------------------------------------
    always_comb begin
        tx_cnt    = bank_cnt_q[tx_bank_q];
        entry_sel = mem_q[tx_bank_q][ent_q];
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
        last_idx  = IW'(tx_cnt) * IW'(9) + IW'(3);
`else
        last_idx  = IW'(tx_cnt) * IW'(9) + IW'(2);
`endif
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_entry_bytes
            assign entry_bytes[gi] = entry_sel[71 - 8*gi -: 8];
        end
    endgenerate

    always_comb begin
        if (idx_q == IW'(0)) begin
            frame_byte = SYNC;
        end else if (idx_q == IW'(1)) begin
            frame_byte = seq_q;
        end else if (idx_q == IW'(2)) begin
            frame_byte = 8'(tx_cnt);
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
        end else if (idx_q == last_idx) begin
            frame_byte = cks_q;
`endif
        end else begin
            frame_byte = entry_bytes[off_q];
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= TX_IDLE;
            tx_bank_q <= 1'b0;
            seq_q     <= 8'd0;
            idx_q     <= '0;
            ent_q     <= '0;
            off_q     <= 4'd0;
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
            cks_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            tx_bank_q <= tx_bank_d;
            seq_q     <= seq_d;
            idx_q     <= idx_d;
            ent_q     <= ent_d;
            off_q     <= off_d;
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
            cks_q     <= cks_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tx_bank_d  = tx_bank_q;
        seq_d      = seq_q;
        idx_d      = idx_q;
        ent_d      = ent_q;
        off_d      = off_q;
        tx_release = 1'b0;
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
        cks_d      = cks_q;
`endif

        unique case (state_q)
            TX_IDLE: begin
                if (bank_full_q[tx_bank_q]) begin
                    state_d = TX_SEND;
                    idx_d   = '0;
                    ent_d   = '0;
                    off_d   = 4'd0;
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
                    cks_d   = 8'd0;
`endif
                end
            end
            TX_SEND: begin
                if (source_ready) begin
                    if (idx_q == last_idx) begin
                        // Frame done: free the bank and go straight on to the
                        // other bank when it is already waiting.
                        tx_release = 1'b1;
                        seq_d      = seq_q + 8'd1;
                        tx_bank_d  = ~tx_bank_q;
                        idx_d      = '0;
                        ent_d      = '0;
                        off_d      = 4'd0;
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
                        cks_d      = 8'd0;
`endif
                        state_d    = bank_full_q[~tx_bank_q] ? TX_SEND : TX_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
                        cks_d = cks_q + frame_byte;
`endif
                        // Entry bytes start at index 3; nine bytes per entry.
                        if (idx_q >= IW'(3)) begin
                            if (off_q == 4'd8) begin
                                off_d = 4'd0;
                                ent_d = ent_q + EW'(1);
                            end else begin
                                off_d = off_q + 4'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Transmit FSM: outputs (forced to zero whenever no byte is offered)
    // -------------------------------------------------------------------------
    always_comb begin
        source_valid = (state_q == TX_SEND);
        source_data  = source_valid ? frame_byte : 8'd0;
        source_sop   = source_valid && (idx_q == IW'(0));
        source_eop   = source_valid && (idx_q == last_idx);
    end

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_phase_packetizer.sv
`timescale 1ns/1ps
module tb_phase_packetizer;

    typedef logic [7:0]  bq_t[$];
    typedef logic [71:0] eq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sink_valid = 1'b0;
    logic        sink_sop = 1'b0;
    logic        sink_eop = 1'b0;
    logic [23:0] sink_freq = '0;
    logic [15:0] sink_phaseA = '0;
    logic [15:0] sink_phaseB = '0;
    logic        source_valid;
    logic        source_ready = 1'b0;
    logic [7:0]  source_data;
    logic        source_sop;
    logic        source_eop;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int failed = 0;

    phase_packetizer dut (
        .clk          (clk),
        .reset        (reset),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_freq    (sink_freq),
        .sink_phaseA  (sink_phaseA),
        .sink_phaseB  (sink_phaseB),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_data  (source_data),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame from hand-written entry words {freq, A, B, diff}.
    function automatic bq_t build(input logic [7:0] seq, input eq_t ents);
        bq_t         q;
        int          n;
        logic [71:0] w;
        logic [7:0]  s;
        n = (ents.size() > 4) ? 4 : ents.size();
        q.push_back(8'hA5);
        q.push_back(seq);
        q.push_back(8'(n));
        for (int e = 0; e < n; e++) begin
            w = ents[e];
            for (int b = 0; b < 9; b++) q.push_back(w[71 - 8*b -: 8]);
        end
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
        s = 8'd0;
        foreach (q[k]) s = s + q[k];
        q.push_back(s);
`endif
        return q;
    endfunction

    task automatic send_run(input eq_t ents);
        int n;
        n = ents.size();
        for (int i = 0; i < n; i++) begin
            sink_valid  = 1'b1;
            sink_sop    = (i == 0);
            sink_eop    = (i == n - 1);
            sink_freq   = ents[i][71:48];
            sink_phaseA = ents[i][47:32];
            sink_phaseB = ents[i][31:16];
            tick();
        end
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    // mode 0: ready held 1; mode 1: ready toggles 0/1 every cycle.
    task automatic recv(input string tag, input bq_t exp, input int mode);
        int   n;
        int   i;
        int   budget;
        logic tog;
        n = exp.size();
        i = 0;
        budget = 0;
        tog = 1'b0;
        while (i < n && budget < 400) begin
            source_ready = (mode == 0) ? 1'b1 : tog;
            tog = ~tog;
            if (i > 0) chk({tag, "_valid_held"}, 32'(source_valid), 32'd1);
            if (source_valid) begin
                chk($sformatf("%s_byte%0d", tag, i), 32'(source_data), 32'(exp[i]));
                chk($sformatf("%s_sop%0d", tag, i), 32'(source_sop), 32'(i == 0));
                chk($sformatf("%s_eop%0d", tag, i), 32'(source_eop), 32'(i == n - 1));
                if (source_ready) i++;
            end
            tick();
            budget++;
        end
        chk({tag, "_bytes_done"}, 32'(i), 32'(n));
        $display("[TB] frame %s: %0d of %0d bytes, %0d cycles", tag, i, n, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        eq_t ents;
        bq_t exp;

        // ---- reset state
        repeat (3) tick();
        chk("rst_valid", 32'(source_valid), 32'd0);
        chk("rst_data",  32'(source_data),  32'd0);
        chk("rst_sop",   32'(source_sop),   32'd0);
        chk("rst_eop",   32'(source_eop),   32'd0);
        chk("rst_drop",  32'(drop_cnt),     32'd0);
        reset = 1'b1;
        tick();

        // ---- single entry, ready=1, latency
        ents = '{72'h0186A0_1000_0800_0800};
        exp = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h86, 8'hA0,
                8'h10, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00};
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
        exp.push_back(8'hED);
`endif
        send_run(ents);
        source_ready = 1'b1;
        tick();
        chk("latency_valid", 32'(source_valid), 32'd1);
        recv("f1", exp, 0);

        // ---- phase wrap both directions, ready toggling
        ents = '{72'h000123_61A8_9E58_FA40, 72'hABCDEF_9E58_61A8_05C0};
        send_run(ents);
        recv("f2_wrap", build(8'h01, ents), 1);

        // ---- six-entry run, only four kept; exact +/-PI boundaries
        ents = '{72'h000011_0200_0100_0100, 72'h000022_0050_0060_FFF0,
                 72'h000033_6489_0000_9B79, 72'h000044_9B78_0000_9B78,
                 72'h000055_1111_2222_EEEF, 72'h000066_3333_1111_2222};
        send_run(ents);
        exp = build(8'h02, ents);
`ifdef PHASE_PACKETIZER_CHECKSUM_EN
        chk("f3_len", 32'(exp.size()), 32'd40);
`else
        chk("f3_len", 32'(exp.size()), 32'd39);
`endif
        recv("f3_trunc", exp, 0);

        // ---- reset pulled low mid-frame
        ents = '{72'h000777_0001_0001_0000};
        send_run(ents);
        source_ready = 1'b1;
        repeat (4) tick();
        chk("mid_active", 32'(source_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(source_valid), 32'd0);
        chk("mid_rst_data",  32'(source_data),  32'd0);
        chk("mid_rst_sop",   32'(source_sop),   32'd0);
        chk("mid_rst_eop",   32'(source_eop),   32'd0);
        tick();
        reset = 1'b1;
        source_ready = 1'b0;
        tick();

        // ---- three runs back to back with ready=0: third dropped
        send_run('{72'h00AAAA_0010_0020_FFF0});
        send_run('{72'h00BBBB_1234_1200_0034, 72'h00CCCC_0000_6489_6487});
        send_run('{72'h00DDDD_0000_0000_0000});
        chk("b2b_drop", 32'(drop_cnt), 32'd1);
        chk("b2b_stall_valid", 32'(source_valid), 32'd1);
        chk("b2b_stall_data",  32'(source_data),  32'hA5);
        recv("b2b_x", build(8'h00, '{72'h00AAAA_0010_0020_FFF0}), 0);
        chk("b2b_next_valid", 32'(source_valid), 32'd1);
        chk("b2b_next_sop",   32'(source_sop),   32'd1);
        recv("b2b_y", build(8'h01, '{72'h00BBBB_1234_1200_0034,
                                     72'h00CCCC_0000_6489_6487}), 0);
        repeat (3) tick();
        chk("b2b_idle_valid", 32'(source_valid), 32'd0);
        chk("b2b_drop_final", 32'(drop_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
